// File: rtl/otter_rvfi_tracer.sv
// RVFI retirement tracer: captures compact records into a FIFO and
// streams each one out as seven 32-bit words on a valid/ready port.
module otter_rvfi_tracer #(
   parameter int DEPTH  = 8,
   parameter int DROP_W = 16
) (
   input  logic                       i_clk,
   input  logic                       i_rst_n,
   input  logic                       i_en,
   input  logic                       i_rvfi_valid,
   input  logic [63:0]                i_rvfi_order,
   input  logic [31:0]                i_rvfi_insn,
   input  logic [31:0]                i_rvfi_pc_rdata,
   input  logic [31:0]                i_rvfi_pc_wdata,
   input  logic [4:0]                 i_rvfi_rd_addr,
   input  logic [31:0]                i_rvfi_rd_wdata,
   input  logic                       i_rvfi_trap,
   input  logic                       i_rvfi_intr,
   input  logic [31:0]                i_rvfi_mem_addr,
   input  logic [3:0]                 i_rvfi_mem_rmask,
   input  logic [3:0]                 i_rvfi_mem_wmask,
   input  logic [31:0]                i_rvfi_mem_rdata,
   input  logic [31:0]                i_rvfi_mem_wdata,
   output logic                       o_tvalid,
   output logic [31:0]                o_tdata,
   output logic                       o_tlast,
   input  logic                       i_tready,
   output logic [$clog2(DEPTH):0]     o_level,
   output logic [DROP_W-1:0]          o_drop_cnt,
   output logic                       o_busy
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   typedef enum logic {IDLE, SEND} state_t;
   typedef logic [6:0][31:0] rec_t;

   rec_t              mem [DEPTH];
   rec_t              rec_in;
   logic [AW-1:0]     wr_ptr, rd_ptr, rd_ptr_inc;
   logic [LW-1:0]     level, level_nxt;
   logic [DROP_W-1:0] drop_cnt;
   logic              gap;
   logic              capture, full, push, drop, pop;

   state_t      state, state_nxt;
   logic [2:0]  idx, idx_nxt, idx_inc;
   logic [31:0] tdata_nxt;
   logic        tvalid_nxt, tlast_nxt;

   logic unused_ok;
   assign unused_ok = ^i_rvfi_order[63:8];

   assign rec_in[0] = {8'hA5, gap, i_rvfi_trap, i_rvfi_intr,
                       i_rvfi_rd_addr, i_rvfi_mem_rmask,
                       i_rvfi_mem_wmask, i_rvfi_order[7:0]};
   assign rec_in[1] = i_rvfi_pc_rdata;
   assign rec_in[2] = i_rvfi_pc_wdata;
   assign rec_in[3] = i_rvfi_insn;
   assign rec_in[4] = i_rvfi_rd_wdata;
   assign rec_in[5] = i_rvfi_mem_addr;
   assign rec_in[6] = (i_rvfi_mem_wmask != 4'd0) ? i_rvfi_mem_wdata
                                                 : i_rvfi_mem_rdata;

   // Full is judged on the registered level; a same-cycle pop frees nothing.
   assign capture    = i_rvfi_valid && i_en;
   assign full       = (level == LW'(DEPTH));
   assign push       = capture && !full;
   assign drop       = capture && full;
   assign pop        = (state == SEND) && o_tvalid && i_tready &&
                       (idx == 3'd6);
   assign level_nxt  = level + LW'(push) - LW'(pop);
   assign rd_ptr_inc = rd_ptr + AW'(1);
   assign idx_inc    = idx + 3'd1;

   always_ff @(posedge i_clk) begin
      if (push) mem[wr_ptr] <= rec_in;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         level    <= '0;
         drop_cnt <= '0;
         gap      <= 1'b0;
      end else begin
         level <= level_nxt;
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
            gap    <= 1'b0;
         end
         if (pop) rd_ptr <= rd_ptr_inc;
         if (drop) begin
            gap <= 1'b1;
            if (drop_cnt != '1) drop_cnt <= drop_cnt + DROP_W'(1);
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state    <= IDLE;
         idx      <= 3'd0;
         o_tdata  <= '0;
         o_tvalid <= 1'b0;
         o_tlast  <= 1'b0;
      end else begin
         state    <= state_nxt;
         idx      <= idx_nxt;
         o_tdata  <= tdata_nxt;
         o_tvalid <= tvalid_nxt;
         o_tlast  <= tlast_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      idx_nxt    = idx;
      tdata_nxt  = o_tdata;
      tvalid_nxt = o_tvalid;
      tlast_nxt  = o_tlast;
      unique case (state)
         IDLE: begin
            if (level != '0) begin
               state_nxt  = SEND;
               idx_nxt    = 3'd0;
               tdata_nxt  = mem[rd_ptr][0];
               tvalid_nxt = 1'b1;
               tlast_nxt  = 1'b0;
            end
         end
         SEND: begin
            if (o_tvalid && i_tready) begin
               if (idx != 3'd6) begin
                  idx_nxt   = idx_inc;
                  tdata_nxt = mem[rd_ptr][idx_inc];
                  tlast_nxt = (idx == 3'd5);
               end else if (level_nxt != '0) begin
                  // With one entry left, the follow-on record is the one
                  // being written this very edge, so take it from the input.
                  idx_nxt   = 3'd0;
                  tdata_nxt = (level == LW'(1)) ? rec_in[0]
                                                : mem[rd_ptr_inc][0];
                  tlast_nxt = 1'b0;
               end else begin
                  state_nxt  = IDLE;
                  idx_nxt    = 3'd0;
                  tdata_nxt  = '0;
                  tvalid_nxt = 1'b0;
                  tlast_nxt  = 1'b0;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign o_level    = level;
   assign o_drop_cnt = drop_cnt;
   assign o_busy     = (level != '0) || (state != IDLE);

endmodule

// File: tb/tb_otter_rvfi_tracer.sv
// Bench for otter_rvfi_tracer: directed and random retirements checked
// against a queue-of-records model of the trace stream.
module tb_otter_rvfi_tracer;

   localparam int DEPTH  = 8;
   localparam int DROP_W = 16;

   typedef logic [6:0][31:0] rec_t;

   logic        i_clk = 1'b0;
   logic        i_rst_n = 1'b0;
   logic        i_en = 1'b0;
   logic        i_rvfi_valid = 1'b0;
   logic [63:0] i_rvfi_order = '0;
   logic [31:0] i_rvfi_insn = '0;
   logic [31:0] i_rvfi_pc_rdata = '0;
   logic [31:0] i_rvfi_pc_wdata = '0;
   logic [4:0]  i_rvfi_rd_addr = '0;
   logic [31:0] i_rvfi_rd_wdata = '0;
   logic        i_rvfi_trap = 1'b0;
   logic        i_rvfi_intr = 1'b0;
   logic [31:0] i_rvfi_mem_addr = '0;
   logic [3:0]  i_rvfi_mem_rmask = '0;
   logic [3:0]  i_rvfi_mem_wmask = '0;
   logic [31:0] i_rvfi_mem_rdata = '0;
   logic [31:0] i_rvfi_mem_wdata = '0;
   logic        o_tvalid;
   logic [31:0] o_tdata;
   logic        o_tlast;
   logic        i_tready = 1'b0;
   logic [$clog2(DEPTH):0] o_level;
   logic [DROP_W-1:0]      o_drop_cnt;
   logic        o_busy;

   otter_rvfi_tracer #(.DEPTH(DEPTH), .DROP_W(DROP_W)) dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_en(i_en),
      .i_rvfi_valid(i_rvfi_valid), .i_rvfi_order(i_rvfi_order),
      .i_rvfi_insn(i_rvfi_insn), .i_rvfi_pc_rdata(i_rvfi_pc_rdata),
      .i_rvfi_pc_wdata(i_rvfi_pc_wdata), .i_rvfi_rd_addr(i_rvfi_rd_addr),
      .i_rvfi_rd_wdata(i_rvfi_rd_wdata), .i_rvfi_trap(i_rvfi_trap),
      .i_rvfi_intr(i_rvfi_intr), .i_rvfi_mem_addr(i_rvfi_mem_addr),
      .i_rvfi_mem_rmask(i_rvfi_mem_rmask),
      .i_rvfi_mem_wmask(i_rvfi_mem_wmask),
      .i_rvfi_mem_rdata(i_rvfi_mem_rdata),
      .i_rvfi_mem_wdata(i_rvfi_mem_wdata),
      .o_tvalid(o_tvalid), .o_tdata(o_tdata), .o_tlast(o_tlast),
      .i_tready(i_tready), .o_level(o_level), .o_drop_cnt(o_drop_cnt),
      .o_busy(o_busy)
   );

   always #5 i_clk = ~i_clk;

   int errors = 0;
   int checks = 0;

   // Model: records awaiting export, position in the current record.
   rec_t              mq[$];
   bit                m_send;
   int                m_idx;
   bit                m_gap;
   logic [DROP_W-1:0] m_drop;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      m_send = 0;
      m_idx  = 0;
      m_gap  = 0;
      m_drop = '0;
   endtask

   function automatic rec_t mk_rec();
      rec_t r;
      r[0] = {8'hA5, m_gap, i_rvfi_trap, i_rvfi_intr, i_rvfi_rd_addr,
              i_rvfi_mem_rmask, i_rvfi_mem_wmask, i_rvfi_order[7:0]};
      r[1] = i_rvfi_pc_rdata;
      r[2] = i_rvfi_pc_wdata;
      r[3] = i_rvfi_insn;
      r[4] = i_rvfi_rd_wdata;
      r[5] = i_rvfi_mem_addr;
      r[6] = (i_rvfi_mem_wmask != 0) ? i_rvfi_mem_wdata : i_rvfi_mem_rdata;
      return r;
   endfunction

   task automatic check_outputs();
      chk("tvalid", 64'(o_tvalid), 64'(m_send));
      chk("tlast", 64'(o_tlast), 64'(m_send && m_idx == 6));
      if (m_send) chk("tdata", 64'(o_tdata), 64'(mq[0][m_idx]));
      chk("level", 64'(o_level), 64'(mq.size()));
      chk("drop_cnt", 64'(o_drop_cnt), 64'(m_drop));
      chk("busy", 64'(o_busy), 64'(mq.size() != 0 || m_send));
   endtask

   // One clock: check current outputs, drive inputs, predict the edge.
   task automatic cyc(input bit v, input bit rdy, input bit en,
                      input bit rnd);
      rec_t r;
      bit   cap, full, ok, hs;
      int   sz;
      check_outputs();
      if (rnd) begin
         i_rvfi_order     = {$urandom, $urandom};
         i_rvfi_insn      = $urandom;
         i_rvfi_pc_rdata  = $urandom;
         i_rvfi_pc_wdata  = $urandom;
         i_rvfi_rd_addr   = 5'($urandom);
         i_rvfi_rd_wdata  = $urandom;
         i_rvfi_trap      = 1'($urandom);
         i_rvfi_intr      = 1'($urandom);
         i_rvfi_mem_addr  = $urandom;
         i_rvfi_mem_rmask = 4'($urandom);
         i_rvfi_mem_wmask = ($urandom_range(0, 2) == 0) ? 4'd0
                                                        : 4'($urandom);
         i_rvfi_mem_rdata = $urandom;
         i_rvfi_mem_wdata = $urandom;
      end
      i_rvfi_valid = v;
      i_tready     = rdy;
      i_en         = en;
      r    = mk_rec();
      cap  = v && en;
      sz   = mq.size();
      full = (sz >= DEPTH);
      ok   = cap && !full;
      hs   = m_send && rdy;
      if (cap && full) begin
         if (m_drop != '1) m_drop++;
         m_gap = 1;
      end
      if (!m_send) begin
         if (sz != 0) begin
            m_send = 1;
            m_idx  = 0;
         end
      end else if (hs) begin
         if (m_idx == 6) begin
            void'(mq.pop_front());
            m_idx  = 0;
            m_send = ((sz - 1 + int'(ok)) != 0);
         end else begin
            m_idx++;
         end
      end
      if (ok) begin
         mq.push_back(r);
         m_gap = 0;
      end
      @(posedge i_clk);
      @(negedge i_clk);
   endtask

   task automatic drain(input string tag);
      for (int i = 0; i < 300 && (mq.size() != 0 || m_send); i++)
         cyc(0, 1, 1, 1);
      cyc(0, 1, 1, 1);
      chk({tag, "_drained"}, 64'(o_busy), 64'(0));
   endtask

   task automatic set_fixed(input logic [31:0] pc, input logic [31:0] insn,
                            input logic [4:0] rd, input logic [31:0] wd,
                            input logic [7:0] ord, input logic [3:0] rm,
                            input logic [3:0] wm, input logic [31:0] rdat,
                            input logic [31:0] wdat);
      i_rvfi_pc_rdata  = pc;
      i_rvfi_pc_wdata  = pc + 32'd4;
      i_rvfi_insn      = insn;
      i_rvfi_rd_addr   = rd;
      i_rvfi_rd_wdata  = wd;
      i_rvfi_order     = 64'(ord);
      i_rvfi_trap      = 1'b0;
      i_rvfi_intr      = 1'b0;
      i_rvfi_mem_addr  = 32'h0;
      i_rvfi_mem_rmask = rm;
      i_rvfi_mem_wmask = wm;
      i_rvfi_mem_rdata = rdat;
      i_rvfi_mem_wdata = wdat;
   endtask

   initial begin
      model_reset();
      #3;
      chk("rst_tvalid", 64'(o_tvalid), 64'(0));
      chk("rst_tdata", 64'(o_tdata), 64'(0));
      chk("rst_level", 64'(o_level), 64'(0));
      chk("rst_busy", 64'(o_busy), 64'(0));
      @(negedge i_clk);
      i_rst_n = 1'b1;
      @(negedge i_clk);

      // Single record, sink always ready.
      set_fixed(32'h100, 32'h00500093, 5'd1, 32'd5, 8'd3, 4'd0, 4'd0,
                32'd0, 32'd0);
      cyc(1, 1, 1, 0);
      chk("e0_tvalid", 64'(o_tvalid), 64'(0));
      cyc(0, 1, 1, 0);
      chk("e1_tvalid", 64'(o_tvalid), 64'(1));
      chk("e1_header", 64'(o_tdata), 64'(32'hA5010003));
      drain("single");

      // Back-pressure pattern 1,0,0,1,...
      cyc(1, 1, 1, 1);
      cyc(1, 1, 1, 1);
      for (int i = 0; i < 40; i++) cyc(0, (i % 3) == 0, 1, 1);
      drain("bp");

      // Capture disabled: nothing enters.
      for (int i = 0; i < 4; i++) cyc(1, 1, 0, 1);
      chk("en_off_level", 64'(o_level), 64'(0));

      // Store then load.
      set_fixed(32'h200, 32'h00b12023, 5'd0, 32'd0, 8'd10, 4'd0, 4'b0011,
                32'hDEAD0000, 32'hBEEF);
      cyc(1, 1, 1, 0);
      set_fixed(32'h204, 32'h00012283, 5'd5, 32'h12345678, 8'd11,
                4'b1111, 4'd0, 32'h12345678, 32'hFFFF);
      cyc(1, 1, 1, 0);
      drain("ldst");

      // Overflow with the sink stalled.
      for (int i = 0; i < 12; i++) cyc(1, 0, 1, 1);
      chk("ovf_level", 64'(o_level), 64'(8));
      chk("ovf_drop", 64'(o_drop_cnt), 64'(4));
      for (int i = 0; i < 20 && mq.size() == DEPTH; i++) cyc(0, 1, 1, 1);
      chk("ovf_popped", 64'(o_level), 64'(7));
      cyc(1, 1, 1, 1);
      cyc(1, 1, 1, 1);
      drain("ovf");

      // Capture coinciding with the final handshake of a record.
      cyc(1, 0, 1, 1);
      cyc(1, 0, 1, 1);
      for (int i = 0; i < 20 && !(m_send && m_idx == 6); i++)
         cyc(0, 1, 1, 1);
      cyc(1, 1, 1, 1);
      chk("b2b_level", 64'(o_level), 64'(2));
      chk("b2b_tvalid", 64'(o_tvalid), 64'(1));
      drain("b2b");

      // Asynchronous reset in the middle of a record.
      cyc(1, 1, 1, 1);
      for (int i = 0; i < 20 && !(m_send && m_idx == 3); i++)
         cyc(0, 1, 1, 1);
      chk("mid_tvalid", 64'(o_tvalid), 64'(1));
      #1 i_rst_n = 1'b0;
      #1;
      chk("arst_tvalid", 64'(o_tvalid), 64'(0));
      chk("arst_level", 64'(o_level), 64'(0));
      chk("arst_drop", 64'(o_drop_cnt), 64'(0));
      chk("arst_tlast", 64'(o_tlast), 64'(0));
      model_reset();
      @(negedge i_clk);
      i_rst_n = 1'b1;
      cyc(1, 1, 1, 1);
      cyc(0, 1, 1, 1);
      drain("post_rst");

      // Random traffic.
      for (int i = 0; i < 600; i++)
         cyc($urandom_range(0, 2) != 0, 1'($urandom),
             $urandom_range(0, 9) != 0, 1);
      drain("rand");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
